// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and constants for the adder arbiter slice.
//   t_arb_state  : arbiter FSM state encoding
//   C_DATA_WIDTH : default operand width
//   C_RES_WIDTH  : default result width (one carry bit wider than the operands)
//   f_ptr_width  : width of a requester index / round-robin pointer
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int C_DATA_WIDTH = 6;
    localparam int C_RES_WIDTH  = C_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } t_arb_state;

    // At least one bit, so that a degenerate requester count still gets a legal vector.
    function automatic int f_ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_chk.sv
// -----------------------------------------------------------------------------
// adder_arbiter_chk
// Protocol properties of the adder arbiter, observed from its ports.
//   clk, rst_n  : clock and async active-low reset of the arbiter
//   req_ready   : at most one requester accepted at a time
//   rsp_valid   : at most one response driven at a time
//   rsp_ready   : response accept, used to detect a stalled response
//   rsp_c       : response sum, must hold while a response is stalled
//   add_valid   : adder issue strobe, a single-cycle pulse
// -----------------------------------------------------------------------------
module adder_arbiter_chk #(
    parameter int g_num_req   = 4,
    parameter int g_res_width = 7
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic [g_num_req-1:0]   req_ready,
    input logic [g_num_req-1:0]   rsp_valid,
    input logic [g_num_req-1:0]   rsp_ready,
    input logic [g_res_width-1:0] rsp_c,
    input logic                   add_valid
);

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));

    a_add_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        add_valid |=> !add_valid);

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ((|rsp_valid) && !(|(rsp_valid & rsp_ready)))
        |=> ($stable(rsp_c) && (rsp_valid == $past(rsp_valid))));

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches the request vector starting at
// rr_ptr and wrapping modulo g_num_req; the first set bit wins.
//   req        in  g_num_req  request vector
//   rr_ptr     in  PTR_W      index searched first
//   gnt_onehot out g_num_req  one-hot winner (all zero when nothing requests)
//   gnt_idx    out PTR_W      binary index of the winner
//   gnt_any    out 1          some request was selected
// The pointer register itself lives in the caller.
// -----------------------------------------------------------------------------
module rr_arbiter
    import adder_pkg::*;
#(
    parameter int g_num_req = 4,
    localparam int C_PTR_W  = f_ptr_width(g_num_req)
) (
    input  logic [g_num_req-1:0] req,
    input  logic [C_PTR_W-1:0]   rr_ptr,
    output logic [g_num_req-1:0] gnt_onehot,
    output logic [C_PTR_W-1:0]   gnt_idx,
    output logic                 gnt_any
);

    int   cand_s;
    logic hit_s;
    logic found_s;

    // Priority search rotated by rr_ptr; hit_s is the first request met on the way round.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        cand_s     = 0;
        hit_s      = 1'b0;
        found_s    = 1'b0;
        for (int i = 0; i < g_num_req; i++) begin
            cand_s             = (int'(rr_ptr) + i) % g_num_req;
            hit_s              = req[cand_s] & ~found_s;
            gnt_onehot[cand_s] = hit_s;
            gnt_idx            = hit_s ? C_PTR_W'(cand_s) : gnt_idx;
            found_s            = found_s | hit_s;
        end
        gnt_any = found_s;
    end

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// Shares one registered adder (one-cycle latency, o_valid pulse) between
// g_num_req requesters with round-robin selection and a single operation in
// flight. A watchdog turns a missing adder result into an error response.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid      per-requester request valid
//   i_req_A/i_req_B  packed operands, requester k at [k*W +: W]
//   o_req_ready      one-hot request accept (combinational in S_IDLE)
//   o_rsp_valid      one-hot response valid
//   o_rsp_C          response sum (all ones on timeout), qualified by o_rsp_valid
//   o_rsp_err        response is a timeout error, qualified by o_rsp_valid
//   i_rsp_ready      per-requester response accept
//   o_add_valid/o_add_A/o_add_B   adder issue interface
//   i_add_valid/i_add_C           adder result interface
//   o_busy           high whenever the FSM is not in S_IDLE
//   o_timeout_err    sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int g_data_width = C_DATA_WIDTH,
    parameter int g_num_req    = 4,
    parameter int g_timeout    = 8,
    parameter bit g_enable_chk = 1'b1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [g_num_req-1:0]              i_req_valid,
    input  logic [g_num_req*g_data_width-1:0] i_req_A,
    input  logic [g_num_req*g_data_width-1:0] i_req_B,
    output logic [g_num_req-1:0]              o_req_ready,
    output logic [g_num_req-1:0]              o_rsp_valid,
    output logic [g_data_width:0]             o_rsp_C,
    output logic                              o_rsp_err,
    input  logic [g_num_req-1:0]              i_rsp_ready,
    output logic                              o_add_valid,
    output logic [g_data_width-1:0]           o_add_A,
    output logic [g_data_width-1:0]           o_add_B,
    input  logic                              i_add_valid,
    input  logic [g_data_width:0]             i_add_C,
    output logic                              o_busy,
    output logic                              o_timeout_err
);

    localparam int C_PTR_W = f_ptr_width(g_num_req);
    localparam int C_RES_W = g_data_width + 1;
    localparam int C_CNT_W = $clog2(g_timeout);

    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(g_num_req - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(g_timeout - 1);

    t_arb_state                state_r;
    logic [C_PTR_W-1:0]        rr_ptr_r;
    logic [C_PTR_W-1:0]        grant_r;
    logic [g_data_width-1:0]   a_r;
    logic [g_data_width-1:0]   b_r;
    logic [C_RES_W-1:0]        res_r;
    logic                      err_r;
    logic [C_CNT_W-1:0]        cnt_r;
    logic                      add_valid_r;
    logic [g_num_req-1:0]      rsp_valid_r;
    logic                      timeout_err_r;

    logic [g_num_req-1:0]      arb_gnt_s;
    logic [C_PTR_W-1:0]        arb_idx_s;
    logic                      arb_any_s;
    logic [g_num_req-1:0]      ready_s;
    logic [g_data_width-1:0]   sel_a_s;
    logic [g_data_width-1:0]   sel_b_s;
    logic [g_num_req-1:0]      rsp_onehot_s;
    logic                      rsp_hs_s;
    logic [C_PTR_W-1:0]        ptr_next_s;

    rr_arbiter #(
        .g_num_req (g_num_req)
    ) u_rr_arbiter (
        .req        (i_req_valid),
        .rr_ptr     (rr_ptr_r),
        .gnt_onehot (arb_gnt_s),
        .gnt_idx    (arb_idx_s),
        .gnt_any    (arb_any_s)
    );

    // Request accept is only offered in S_IDLE, and never while reset is asserted.
    always_comb begin
        ready_s = '0;
        if ((state_r == S_IDLE) && i_rst_n) begin
            ready_s = arb_gnt_s;
        end else begin
            ready_s = '0;
        end
    end

    // Operand mux, response one-hot and handshake/pointer helpers.
    always_comb begin
        sel_a_s               = i_req_A[int'(arb_idx_s)*g_data_width +: g_data_width];
        sel_b_s               = i_req_B[int'(arb_idx_s)*g_data_width +: g_data_width];
        rsp_onehot_s          = '0;
        rsp_onehot_s[grant_r] = 1'b1;
        rsp_hs_s              = (state_r == S_RESP) && i_rsp_ready[grant_r];
        ptr_next_s            = (arb_idx_s == C_PTR_LAST) ? '0 : (arb_idx_s + C_PTR_W'(1));
    end

    // Arbiter FSM with all datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= S_IDLE;
            rr_ptr_r      <= '0;
            grant_r       <= '0;
            a_r           <= '0;
            b_r           <= '0;
            res_r         <= '0;
            err_r         <= 1'b0;
            cnt_r         <= '0;
            add_valid_r   <= 1'b0;
            rsp_valid_r   <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (arb_any_s) begin
                        grant_r     <= arb_idx_s;
                        a_r         <= sel_a_s;
                        b_r         <= sel_b_s;
                        rr_ptr_r    <= ptr_next_s;
                        add_valid_r <= 1'b1;
                        state_r     <= S_ISSUE;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    add_valid_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_add_valid) begin
                        res_r       <= i_add_C;
                        err_r       <= 1'b0;
                        rsp_valid_r <= rsp_onehot_s;
                        state_r     <= S_RESP;
                    end else if (cnt_r == C_CNT_LAST) begin
                        // All-ones is never a legal sum, so it doubles as the error pattern.
                        res_r         <= '1;
                        err_r         <= 1'b1;
                        timeout_err_r <= 1'b1;
                        rsp_valid_r   <= rsp_onehot_s;
                        state_r       <= S_RESP;
                    end else begin
                        cnt_r <= cnt_r + C_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= '0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r     <= S_RESP;
                    end
                end
                default: begin
                    add_valid_r <= 1'b0;
                    rsp_valid_r <= '0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = ready_s;
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_C       = res_r;
    assign o_rsp_err     = err_r;
    assign o_add_valid   = add_valid_r;
    assign o_add_A       = a_r;
    assign o_add_B       = b_r;
    assign o_busy        = (state_r != S_IDLE);
    assign o_timeout_err = timeout_err_r;

    generate
        if (g_enable_chk) begin : g_chk
            adder_arbiter_chk #(
                .g_num_req   (g_num_req),
                .g_res_width (C_RES_W)
            ) u_chk (
                .clk       (i_clk),
                .rst_n     (i_rst_n),
                .req_ready (ready_s),
                .rsp_valid (rsp_valid_r),
                .rsp_ready (i_rsp_ready),
                .rsp_c     (res_r),
                .add_valid (add_valid_r)
            );
        end
    endgenerate

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
// Self-checking bench for adder_arbiter with a behavioural adder stub.
// Directed scenarios followed by a randomized run against a transaction-level
// model (pending requests, round-robin pointer, accept-time arithmetic).
// -----------------------------------------------------------------------------
module tb_adder_arbiter;
    import adder_pkg::*;

    localparam int W  = 6;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int RW = W + 1;

    logic           i_clk   = 1'b0;
    logic           i_rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_A = '0;
    logic [N*W-1:0] req_B = '0;
    logic [N-1:0]   rsp_ready = '0;
    logic [N-1:0]   o_req_ready;
    logic [N-1:0]   o_rsp_valid;
    logic [RW-1:0]  o_rsp_C;
    logic           o_rsp_err;
    logic           o_add_valid;
    logic [W-1:0]   o_add_A;
    logic [W-1:0]   o_add_B;
    logic           o_busy;
    logic           o_timeout_err;
    logic           add_valid_m = 1'b0;
    logic [RW-1:0]  add_C_m = '0;
    logic           adder_stall = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_ptr  = 0;

    adder_arbiter #(
        .g_data_width (W),
        .g_num_req    (N),
        .g_timeout    (TO),
        .g_enable_chk (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (req_valid),
        .i_req_A       (req_A),
        .i_req_B       (req_B),
        .o_req_ready   (o_req_ready),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_C       (o_rsp_C),
        .o_rsp_err     (o_rsp_err),
        .i_rsp_ready   (rsp_ready),
        .o_add_valid   (o_add_valid),
        .o_add_A       (o_add_A),
        .o_add_B       (o_add_B),
        .i_add_valid   (add_valid_m),
        .i_add_C       (add_C_m),
        .o_busy        (o_busy),
        .o_timeout_err (o_timeout_err)
    );

    // Free-running 100 MHz clock.
    always #5 i_clk = ~i_clk;

    // Adder stub: registered sum, one-cycle latency, can be stalled to force a timeout.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            add_valid_m <= 1'b0;
            add_C_m     <= '0;
        end else begin
            add_valid_m <= o_add_valid & ~adder_stall;
            add_C_m     <= RW'(o_add_A) + RW'(o_add_B);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
        cyc++;
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_A[k*W +: W] = a;
        req_B[k*W +: W] = b;
    endtask

    task automatic do_reset();
        i_rst_n   = 1'b0;
        req_valid = '0;
        #1;
        step();
        i_rst_n = 1'b1;
        m_ptr   = 0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #3;
        n_chk++;
        if ({o_req_ready, o_rsp_valid, o_rsp_C, o_rsp_err, o_add_valid, o_add_A, o_add_B,
             o_busy, o_timeout_err} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b C=%0d add=%b busy=%b, all required 0",
                     o_req_ready, o_rsp_valid, o_rsp_C, o_add_valid, o_busy);
        end
        step();
        #1;
        n_chk++;
        if ({o_req_ready, o_busy, o_add_valid} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_clocked: got ready=%b busy=%b add=%b, required 0",
                     o_req_ready, o_busy, o_add_valid);
        end
        req_valid = '0;
        i_rst_n   = 1'b1;
        m_ptr     = 0;
    endtask

    task automatic test_single();
        set_op(0, 6'd5, 6'd9);
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b required 0001", o_req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_chk++;
        if ({o_add_valid, o_add_A, o_add_B, o_busy} !== {1'b1, 6'd5, 6'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got valid=%b A=%0d B=%0d busy=%b required 1/5/9/1",
                     o_add_valid, o_add_A, o_add_B, o_busy);
        end
        step();
        #1;
        n_chk++;
        if ({o_add_valid, o_rsp_valid} !== 5'd0) begin
            n_fail++; $display("FAIL single_wait: got add=%b rsp=%b required 0", o_add_valid, o_rsp_valid);
        end
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C, o_rsp_err} !== {4'b0001, 7'd14, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got rsp=%b C=%0d err=%b required 0001/14/0",
                     o_rsp_valid, o_rsp_C, o_rsp_err);
        end
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_busy} !== 5'd0) begin
            n_fail++; $display("FAIL single_done: got rsp=%b busy=%b required 0", o_rsp_valid, o_busy);
        end
        m_ptr = 1;
    endtask

    task automatic test_max_operands();
        set_op(2, 6'd63, 6'd63);
        req_valid = 4'b0100;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL max_ready: got %b required 0100", o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C, o_rsp_err} !== {4'b0100, 7'd126, 1'b0}) begin
            n_fail++;
            $display("FAIL max_rsp: got rsp=%b C=%0d err=%b required 0100/126/0",
                     o_rsp_valid, o_rsp_C, o_rsp_err);
        end
        step();
        m_ptr = 3;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] op_a [N];
        logic [W-1:0] op_b [N];
        logic [N-1:0] exp_v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           k;
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'($urandom);
            op_b[i] = W'($urandom);
            set_op(i, op_a[i], op_b[i]);
        end
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            k = j % N;
            exp_v = '0;
            exp_v[k] = 1'b1;
            #1;
            n_chk++;
            if (o_req_ready !== exp_v) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b required %b", j, o_req_ready, exp_v);
            end
            a = op_a[k];
            b = op_b[k];
            step();
            op_a[k] = W'($urandom);
            op_b[k] = W'($urandom);
            set_op(k, op_a[k], op_b[k]);
            if (j == 4) req_valid = '0;
            #1;
            n_chk++;
            if ({o_add_valid, o_add_A, o_add_B} !== {1'b1, a, b}) begin
                n_fail++;
                $display("FAIL rr_issue%0d: got A=%0d B=%0d required %0d/%0d", j, o_add_A, o_add_B, a, b);
            end
            step();
            step();
            #1;
            n_chk++;
            if ({o_rsp_valid, o_rsp_C} !== {exp_v, RW'(a) + RW'(b)}) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got rsp=%b C=%0d required %b/%0d",
                         j, o_rsp_valid, o_rsp_C, exp_v, RW'(a) + RW'(b));
            end
            step();
        end
        #1;
        n_chk++;
        if ({o_req_ready, o_busy} !== 5'd0) begin
            n_fail++; $display("FAIL rr_quiet: got ready=%b busy=%b required 0", o_req_ready, o_busy);
        end
        // Pointer is 1 now: a lone request from 2, then a lone request from 1 (wraps 3,0,1).
        req_valid = 4'b0100;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL rr_lone2: got %b required 0100", o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        step();
        set_op(1, 6'd20, 6'd22);
        req_valid = 4'b0010;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rr_wrap1: got %b required 0010", o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C} !== {4'b0010, 7'd42}) begin
            n_fail++; $display("FAIL rr_wrap1_rsp: got rsp=%b C=%0d required 0010/42", o_rsp_valid, o_rsp_C);
        end
        step();
        m_ptr = 2;
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RW-1:0] c0;
        a = W'($urandom);
        b = W'($urandom);
        c0 = RW'(a) + RW'(b);
        set_op(0, a, b);
        req_valid = 4'b0001;
        rsp_ready = 4'b0000;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_grant: got %b required 0001", o_req_ready);
        end
        step();
        set_op(2, 6'd7, 6'd8);
        req_valid = 4'b0100;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C} !== {4'b0001, c0}) begin
            n_fail++; $display("FAIL bp_rsp: got rsp=%b C=%0d required 0001/%0d", o_rsp_valid, o_rsp_C, c0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            rsp_ready = (i >= 2) ? 4'b0010 : 4'b0000;
            #1;
            n_chk++;
            if ({o_rsp_valid, o_rsp_C, o_busy, o_req_ready} !== {4'b0001, c0, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got rsp=%b C=%0d busy=%b ready=%b required 0001/%0d/1/0000",
                         i, o_rsp_valid, o_rsp_C, o_busy, o_req_ready, c0);
            end
        end
        rsp_ready = 4'b0001;
        step();
        rsp_ready = 4'b1111;
        #1;
        n_chk++;
        if ({o_busy, o_rsp_valid, o_req_ready} !== {1'b0, 4'b0000, 4'b0100}) begin
            n_fail++;
            $display("FAIL bp_release: got busy=%b rsp=%b ready=%b required 0/0000/0100",
                     o_busy, o_rsp_valid, o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C} !== {4'b0100, 7'd15}) begin
            n_fail++; $display("FAIL bp_next_rsp: got rsp=%b C=%0d required 0100/15", o_rsp_valid, o_rsp_C);
        end
        step();
        m_ptr = 3;
    endtask

    task automatic test_timeout();
        logic [W-1:0] a;
        logic [W-1:0] b;
        adder_stall = 1'b1;
        set_op(3, 6'd1, 6'd1);
        req_valid = 4'b1000;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL to_grant: got %b required 1000", o_req_ready);
        end
        step();
        req_valid = '0;
        for (int i = 0; i < TO; i++) begin
            step();
            #1;
            n_chk++;
            if ({o_rsp_valid, o_busy, o_timeout_err} !== {4'b0000, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL to_wait%0d: got rsp=%b busy=%b terr=%b required 0000/1/0",
                         i, o_rsp_valid, o_busy, o_timeout_err);
            end
        end
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C, o_rsp_err, o_timeout_err} !== {4'b1000, 7'd127, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL to_rsp: got rsp=%b C=%0d err=%b terr=%b required 1000/127/1/1",
                     o_rsp_valid, o_rsp_C, o_rsp_err, o_timeout_err);
        end
        step();
        adder_stall = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        set_op(0, a, b);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C, o_rsp_err, o_timeout_err} !== {4'b0001, RW'(a) + RW'(b), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL to_sticky: got rsp=%b C=%0d err=%b terr=%b required 0001/%0d/0/1",
                     o_rsp_valid, o_rsp_C, o_rsp_err, o_timeout_err, RW'(a) + RW'(b));
        end
        step();
        m_ptr = 1;
    endtask

    task automatic test_async_reset();
        adder_stall = 1'b1;
        set_op(1, 6'd3, 6'd4);
        req_valid = 4'b0010;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL ar_grant: got %b required 0010", o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        #1;
        n_chk++;
        if ({o_busy, o_timeout_err} !== 2'b11) begin
            n_fail++; $display("FAIL ar_prebusy: got busy=%b terr=%b required 1/1", o_busy, o_timeout_err);
        end
        i_rst_n   = 1'b0;
        req_valid = 4'b0010;
        #1;
        n_chk++;
        if ({o_req_ready, o_rsp_valid, o_rsp_C, o_rsp_err, o_add_valid, o_add_A, o_add_B,
             o_busy, o_timeout_err} !== 31'd0) begin
            n_fail++;
            $display("FAIL ar_outputs: got ready=%b busy=%b A=%0d terr=%b C=%0d, all required 0",
                     o_req_ready, o_busy, o_add_A, o_timeout_err, o_rsp_C);
        end
        step();
        adder_stall = 1'b0;
        i_rst_n     = 1'b1;
        m_ptr       = 0;
        set_op(3, 6'd10, 6'd11);
        req_valid = 4'b1010;
        #1;
        n_chk++;
        if (o_req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL ar_first: got %b required 0010", o_req_ready);
        end
        step();
        req_valid = 4'b1000;
        step();
        step();
        #1;
        n_chk++;
        if ({o_rsp_valid, o_rsp_C, o_rsp_err} !== {4'b0010, 7'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL ar_rsp: got rsp=%b C=%0d err=%b required 0010/7/0", o_rsp_valid, o_rsp_C, o_rsp_err);
        end
        step();
        #1;
        n_chk++;
        if (o_req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL ar_second: got %b required 1000", o_req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
        step();
        m_ptr = 0;
    endtask

    task automatic test_random();
        bit           pend [N];
        logic [W-1:0] p_a  [N];
        logic [W-1:0] p_b  [N];
        bit           inflight;
        int           acc_cyc;
        int           k_act;
        logic [W-1:0] a_act;
        logic [W-1:0] b_act;
        int           done;
        int           guard;
        int           k;
        int           c;
        bit           found;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        inflight = 1'b0;
        acc_cyc  = 0;
        k_act    = 0;
        a_act    = '0;
        b_act    = '0;
        done     = 0;
        guard    = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req_valid = '0;
        while (done < 40 && guard < 1500) begin
            step();
            guard++;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    p_a[i]  = W'($urandom);
                    p_b[i]  = W'($urandom);
                    set_op(i, p_a[i], p_b[i]);
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = N'($urandom);
            #1;
            exp_ready = '0;
            found     = 1'b0;
            k         = 0;
            if (!inflight) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (!found && pend[c]) begin
                        found = 1'b1;
                        k     = c;
                    end
                end
            end
            if (found) exp_ready[k] = 1'b1;
            exp_rsp = '0;
            if (inflight && (cyc >= acc_cyc + 3)) exp_rsp[k_act] = 1'b1;
            n_chk++;
            if ({o_req_ready, o_rsp_valid, o_busy} !== {exp_ready, exp_rsp, inflight}) begin
                n_fail++;
                $display("FAIL rnd_ctrl@%0d: got ready=%b rsp=%b busy=%b required %b/%b/%b",
                         cyc, o_req_ready, o_rsp_valid, o_busy, exp_ready, exp_rsp, inflight);
            end
            n_chk++;
            if (o_add_valid !== (inflight && (cyc == acc_cyc + 1))) begin
                n_fail++; $display("FAIL rnd_add_valid@%0d: got %b", cyc, o_add_valid);
            end
            if (inflight && (cyc == acc_cyc + 1)) begin
                n_chk++;
                if ({o_add_A, o_add_B} !== {a_act, b_act}) begin
                    n_fail++;
                    $display("FAIL rnd_operands@%0d: got %0d/%0d required %0d/%0d",
                             cyc, o_add_A, o_add_B, a_act, b_act);
                end
            end
            if (exp_rsp != '0) begin
                n_chk++;
                if ({o_rsp_C, o_rsp_err} !== {RW'(a_act) + RW'(b_act), 1'b0}) begin
                    n_fail++;
                    $display("FAIL rnd_sum@%0d: got C=%0d err=%b required %0d/0",
                             cyc, o_rsp_C, o_rsp_err, RW'(a_act) + RW'(b_act));
                end
            end
            if (found) begin
                inflight = 1'b1;
                acc_cyc  = cyc;
                k_act    = k;
                a_act    = p_a[k];
                b_act    = p_b[k];
                pend[k]  = 1'b0;
                m_ptr    = (k + 1) % N;
            end
            if ((exp_rsp != '0) && rsp_ready[k_act]) begin
                inflight = 1'b0;
                done++;
            end
        end
        n_chk++;
        if (done < 40) begin
            n_fail++; $display("FAIL rnd_progress: got %0d operations required 40", done);
        end
        req_valid = '0;
        rsp_ready = 4'b1111;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single();
        test_max_operands();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one adder datapath instance (registered A+B, one-cycle latency, o_valid pulse) between g_num_req requesters.
- Round-robin arbitration with one operation outstanding at a time.
- Per-requester valid/ready request and response handshakes.
- Watchdog flags an adder that fails to return a result.
- Sits between requesting engines and the adder in the datapath top level.

Parameters:
- g_data_width, 6, operand width; result width is g_data_width+1.
- g_num_req, 4, number of requesters (2..8).
- g_timeout, 8, cycles allowed in S_WAIT before a timeout (>=2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  g_num_req  per-requester request valid.
- i_req_A  in  g_num_req*g_data_width  packed operand A; requester k occupies slice [k*W +: W].
- i_req_B  in  g_num_req*g_data_width  packed operand B, same packing.
- o_req_ready  out  g_num_req  one-hot request accept.
- o_rsp_valid  out  g_num_req  one-hot response valid.
- o_rsp_C  out  g_data_width+1  response sum; shared bus, qualified by o_rsp_valid.
- o_rsp_err  out  1  response carries a timeout error, qualified by o_rsp_valid.
- i_rsp_ready  in  g_num_req  per-requester response accept.
- o_add_valid  out  1  drives the adder's i_valid.
- o_add_A  out  g_data_width  drives the adder's i_A.
- o_add_B  out  g_data_width  drives the adder's i_B.
- i_add_valid  in  1  the adder's o_valid.
- i_add_C  in  g_data_width+1  the adder's o_C.
- o_busy  out  1  high in every state except S_IDLE.
- o_timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=S_IDLE, rr_ptr=0, grant=0, operand and result registers=0, timeout counter=0.
  - All outputs 0.
- Reset mid-operation aborts immediately: no response is issued and the requester must re-request.
- The adder's active-high reset is driven from ~i_rst_n at integration.
- S_IDLE:
  - Select the first k with i_req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod g_num_req.
  - o_req_ready[k]=1 combinationally in the same cycle; only one ready bit is ever high.
  - On the handshake: latch k into grant, latch operands A_k and B_k, set rr_ptr=(k+1) mod g_num_req, go to S_ISSUE.
  - With no valid requests, rr_ptr holds and all ready bits stay 0.
- S_ISSUE: o_add_valid=1 for exactly one cycle with the latched operands; go to S_WAIT.
- S_WAIT:
  - o_add_valid=0; o_add_A/o_add_B hold their values.
  - If i_add_valid=1: capture i_add_C, clear the error bit, go to S_RESP.
  - Otherwise the counter increments. When the counter reaches g_timeout-1 without i_add_valid: result='1, error bit=1, o_timeout_err<=1, go to S_RESP.
  - i_add_valid outside S_WAIT is ignored.
- S_RESP:
  - o_rsp_valid[grant]=1; o_rsp_C and o_rsp_err are held stable.
  - On i_rsp_ready[grant]=1, go to S_IDLE in the next cycle. i_rsp_ready of any other requester is ignored.
- Latency with ready asserted throughout:
  - Request accepted at cycle T.
  - o_add_valid at T+1.
  - Adder result at T+2.
  - o_rsp_valid at T+3, response handshake at T+3.
  - Next grant possible at T+4, so the minimum period is 4 cycles per operation.
- Requester contract:
  - A requester keeps i_req_valid high with stable operands until accepted.
  - Deasserting i_req_valid before acceptance is legal; no grant is given.
- Arithmetic: no width change in the arbiter. The sum is passed through; max legal value is 2*(2^W-1)=126 for W=6, and 127 is reserved as the error pattern.

Decomposition:
- Shared package adder_pkg holds:
  - state enum t_arb_state {S_IDLE, S_ISSUE, S_WAIT, S_RESP}.
  - Constants C_DATA_WIDTH=6 and C_RES_WIDTH=C_DATA_WIDTH+1.
  - Function clog2-based pointer width for g_num_req.
- One sub-module, rr_arbiter (parameter g_num_req):
  - Inputs: request vector and rr_ptr.
  - Output: one-hot grant vector plus binary index.
  - Purely combinational; the pointer register lives in adder_arbiter.
- Assertions, when verification hooks are enabled:
  - At most one bit of o_req_ready is high.
  - At most one bit of o_rsp_valid is high.
  - o_add_valid is a single-cycle pulse.
  - o_rsp_C is stable while o_rsp_valid is held without ready.

Test Plan:
1. Single request: req0 with A=5, B=9, rsp_ready=1 -> ready0 at T, o_add_valid at T+1 with A=5/B=9, o_rsp_valid[0] at T+3, o_rsp_C=14, o_rsp_err=0.
2. Max operands: req2 with A=63, B=63 -> o_rsp_C=126 on o_rsp_valid[2]; no error.
3. Round-robin: all four requesters held valid with rsp_ready=1 -> grant order 0,1,2,3,0 at 4-cycle spacing. Req1 alone after a grant to 2 -> granted next (pointer wrap 3->0->1).
4. Backpressure: rsp_ready0=0 for 5 cycles -> o_rsp_valid[0] and o_rsp_C held constant, no new grants, o_busy=1. Raising rsp_ready1 has no effect; rsp_ready0=1 -> S_IDLE the next cycle.
5. Timeout: i_add_valid tied 0, req3 with A=1, B=1 -> 8 cycles in S_WAIT, then o_rsp_valid[3] with o_rsp_C=127, o_rsp_err=1, o_timeout_err=1 sticky through later good operations until reset.
6. Async reset mid-operation: i_rst_n low during S_WAIT -> all outputs 0 immediately without a clock edge; after release, a request from 1 is granted first (rr_ptr=0 search order).
